o2k_axi_mem_slave: RTL and testbench

AXI4 slave that terminates the oculink-to-kernel (o2k) master port with a local 128-bit scratch memory. Write and read bursts complete in hardware, with no host polling of FIFOs. It sits directly downstream of the oculink master and exposes the same o2k AXI-MM channel set the kernel already uses. Write and read paths are independent state machines sharing one register-array memory.

---
 rtl/o2k_axi_mem_slave.sv | 204 ++++++++++++++++++++
 tb/tb_o2k_axi_mem_slave.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/o2k_axi_mem_slave.sv
// AXI4 slave terminating the o2k master port with a local 128-bit scratch memory.
// Independent write and read FSMs share one register-array memory.
module o2k_axi_mem_slave #(
  parameter int LOG2_DEPTH = 9,
  parameter int ID_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [63:0]         s_awaddr,
  input  logic [ID_WIDTH-1:0] s_awid,
  input  logic [7:0]          s_awlen,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [127:0]        s_wdata,
  input  logic [15:0]         s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_WIDTH-1:0] s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [63:0]         s_araddr,
  input  logic [ID_WIDTH-1:0] s_arid,
  input  logic [7:0]          s_arlen,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [127:0]        s_rdata,
  output logic [ID_WIDTH-1:0] s_rid,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] IDX_ONE = 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [127:0] mem_q [DEPTH];

  logic [1:0]            w_state_q, w_state_d;
  logic [LOG2_DEPTH-1:0] w_idx_q, w_idx_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_dec_q, w_dec_d;
  logic                  w_slv_q, w_slv_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic [0:0]            r_state_q, r_state_d;
  logic [LOG2_DEPTH-1:0] r_idx_q, r_idx_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_dec_q, r_dec_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic [127:0]          rdata_q, rdata_d;

  logic                  aw_dec, ar_dec, beat_err, w_fire;
  logic [LOG2_DEPTH-1:0] ar_idx;
  logic                  unused_addr_lsb;

  assign aw_dec   = |s_awaddr[63:4+LOG2_DEPTH];
  assign ar_dec   = |s_araddr[63:4+LOG2_DEPTH];
  assign ar_idx   = s_araddr[4 +: LOG2_DEPTH];
  assign beat_err = s_wlast != (w_cnt_q == 8'd0);
  assign w_fire   = (w_state_q == W_DATA) && s_wvalid && !w_dec_q;
  assign unused_addr_lsb = ^{s_awaddr[3:0], s_araddr[3:0]};

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_dec_d   = w_dec_q;
    w_slv_d   = w_slv_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (s_awvalid) begin
        w_state_d = W_DATA;
        w_idx_d   = s_awaddr[4 +: LOG2_DEPTH];
        w_cnt_d   = s_awlen;
        w_dec_d   = aw_dec;
        w_slv_d   = 1'b0;
        bid_d     = s_awid;
      end
      W_DATA: if (s_wvalid) begin
        w_idx_d = w_idx_q + IDX_ONE;
        w_cnt_d = w_cnt_q - 8'd1;
        w_slv_d = w_slv_q | beat_err;
        // Burst length comes from awlen only; wlast just flags a protocol error.
        if (w_cnt_q == 8'd0) begin
          w_state_d = W_RESP;
          bresp_d   = w_dec_q ? 2'd3 : ((w_slv_q | beat_err) ? 2'd2 : 2'd0);
        end
      end
      W_RESP: if (s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      w_dec_q   <= 1'b0;
      w_slv_q   <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'd0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      w_dec_q   <= w_dec_d;
      w_slv_q   <= w_slv_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int k = 0; k < 16; k++) begin
        if (s_wstrb[k]) mem_q[w_idx_q][8*k +: 8] <= s_wdata[8*k +: 8];
      end
    end
  end

  // rdata is loaded from the pre-write array, so a colliding write is not seen.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    r_dec_d   = r_dec_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (s_arvalid) begin
        r_state_d = R_DATA;
        r_idx_d   = ar_idx + IDX_ONE;
        r_cnt_d   = s_arlen;
        r_dec_d   = ar_dec;
        rid_d     = s_arid;
        rresp_d   = ar_dec ? 2'd3 : 2'd0;
        rlast_d   = (s_arlen == 8'd0);
        rdata_d   = ar_dec ? '0 : mem_q[ar_idx];
      end
      R_DATA: if (s_rready) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_idx_d = r_idx_q + IDX_ONE;
          r_cnt_d = r_cnt_q - 8'd1;
          rlast_d = (r_cnt_q == 8'd1);
          rdata_d = r_dec_q ? '0 : mem_q[r_idx_q];
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      r_dec_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= 2'd0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      r_dec_q   <= r_dec_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_awready = (w_state_q == W_IDLE);
  assign s_wready  = (w_state_q == W_DATA);
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bid     = bid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = (r_state_q == R_IDLE);
  assign s_rvalid  = (r_state_q == R_DATA);
  assign s_rid     = rid_q;
  assign s_rresp   = rresp_q;
  assign s_rlast   = rlast_q;
  assign s_rdata   = rdata_q;

endmodule

// File: tb/tb_o2k_axi_mem_slave.sv
// Scoreboard bench for o2k_axi_mem_slave: tasks queue expected B/R responses
// from a flat memory model, monitors pop and compare on each handshake.
module tb_o2k_axi_mem_slave;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [3:0]   id;
  } r_exp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic         clk, rstn;
  logic [63:0]  s_awaddr, s_araddr;
  logic [3:0]   s_awid, s_arid, s_bid, s_rid;
  logic [7:0]   s_awlen, s_arlen;
  logic         s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
  logic [127:0] s_wdata, s_rdata;
  logic [15:0]  s_wstrb;
  logic [1:0]   s_bresp, s_rresp;
  logic         s_bvalid, s_bready, s_arvalid, s_arready;
  logic         s_rlast, s_rvalid, s_rready;

  int errors = 0;
  int checks = 0;
  int rready_mode = 0;

  logic [127:0] model_mem [512];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  r_exp_t rq[$];
  b_exp_t bq[$];

  o2k_axi_mem_slave dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic fill_rand(input int len, input bit rand_strb);
    for (int b = 0; b <= len; b++) begin
      wd[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
      ws[b] = rand_strb ? 16'($urandom()) : 16'hFFFF;
    end
  endtask

  // rst_beat >= 0 pulses reset when that beat is presented instead of completing.
  task automatic do_write(input logic [63:0] addr, input int len, input logic [3:0] id,
                          input int wlast_beat, input int rst_beat);
    bit dec;
    int idx, b, n;
    b_exp_t e;
    dec = |addr[63:13];
    idx = int'(addr[12:4]);
    if (rst_beat < 0) begin
      e.id   = id;
      e.resp = dec ? 2'd3 : ((wlast_beat != len) ? 2'd2 : 2'd0);
      bq.push_back(e);
    end
    @(posedge clk); #1;
    s_awaddr = addr; s_awid = id; s_awlen = 8'(len); s_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_awready) begin
      n++;
      if (n > 300) begin timeout_fail("aw_wait"); s_awvalid = 1'b0; bq.delete(); return; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("aw_to_wready", s_wready, 1'b1);
    b = 0; n = 0;
    while (b <= len) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        s_wvalid = 1'b0;
      end else begin
        s_wdata = wd[b]; s_wstrb = ws[b]; s_wlast = (b == wlast_beat); s_wvalid = 1'b1;
      end
      @(negedge clk);
      if (s_wvalid && b == rst_beat) begin
        rstn = 1'b0;
        #1;
        chk("rst_awready", s_awready, 1'b1);
        chk("rst_wready", s_wready, 1'b0);
        chk("rst_bvalid", s_bvalid, 1'b0);
        @(posedge clk); #1;
        s_wvalid = 1'b0; s_wlast = 1'b0; rstn = 1'b1;
        return;
      end
      if (s_wvalid && s_wready) begin
        if (!dec) begin
          for (int k = 0; k < 16; k++)
            if (ws[b][k]) model_mem[(idx + b) % 512][8*k +: 8] = wd[b][8*k +: 8];
        end
        b++;
      end
      n++;
      if (n > 2000) begin timeout_fail("w_wait"); s_wvalid = 1'b0; bq.delete(); return; end
    end
    @(posedge clk); #1;
    s_wvalid = 1'b0; s_wlast = 1'b0;
    @(negedge clk);
    chk("wlast_to_bvalid", s_bvalid, 1'b1);
    n = 0;
    while (bq.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin timeout_fail("b_wait"); bq.delete(); end
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input int len, input logic [3:0] id);
    bit dec;
    int idx, n;
    r_exp_t e;
    dec = |addr[63:13];
    idx = int'(addr[12:4]);
    for (int b = 0; b <= len; b++) begin
      e.data = dec ? 128'd0 : model_mem[(idx + b) % 512];
      e.resp = dec ? 2'd3 : 2'd0;
      e.last = (b == len);
      e.id   = id;
      rq.push_back(e);
    end
    @(posedge clk); #1;
    s_araddr = addr; s_arid = id; s_arlen = 8'(len); s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_arready) begin
      n++;
      if (n > 300) begin timeout_fail("ar_wait"); s_arvalid = 1'b0; rq.delete(); return; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("ar_to_rvalid", s_rvalid, 1'b1);
    n = 0;
    while (rq.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin timeout_fail("r_wait"); rq.delete(); end
    end
  endtask

  initial begin
    s_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rready_mode)
        0:       s_rready = 1'b1;
        1:       s_rready = ~s_rready;
        default: s_rready = 1'($urandom());
      endcase
    end
  end

  initial begin
    s_bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      s_bready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : r_monitor
    r_exp_t e;
    bit stall, ar_chk;
    logic [127:0] held_data;
    logic held_last;
    stall = 0; ar_chk = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 0; ar_chk = 0;
      end else begin
        if (ar_chk) begin chk("rlast_to_arready", s_arready, 1'b1); ar_chk = 0; end
        if (stall && s_rvalid) begin
          chk("r_stall_data", s_rdata, held_data);
          chk("r_stall_last", s_rlast, held_last);
        end
        if (s_rvalid && s_rready) begin
          stall = 0;
          if (rq.size() == 0) begin
            chk("r_unexpected", 1'b1, 1'b0);
          end else begin
            e = rq.pop_front();
            chk("rdata", s_rdata, e.data);
            chk("rresp", s_rresp, e.resp);
            chk("rlast", s_rlast, e.last);
            chk("rid", s_rid, e.id);
            if (e.last) ar_chk = 1;
          end
        end else if (s_rvalid) begin
          stall = 1; held_data = s_rdata; held_last = s_rlast;
        end else begin
          stall = 0;
        end
      end
    end
  end

  initial begin : b_monitor
    b_exp_t e;
    bit aw_chk;
    aw_chk = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        aw_chk = 0;
      end else begin
        if (aw_chk) begin chk("b_to_awready", s_awready, 1'b1); aw_chk = 0; end
        if (s_bvalid && s_bready) begin
          if (bq.size() == 0) begin
            chk("b_unexpected", 1'b1, 1'b0);
          end else begin
            e = bq.pop_front();
            chk("bid", s_bid, e.id);
            chk("bresp", s_bresp, e.resp);
            aw_chk = 1;
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] addr;
    int len;
    rstn = 1'b0;
    s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
    s_araddr = '0; s_arid = '0; s_arlen = '0; s_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready0", s_awready, 1'b1);
    chk("rst_arready0", s_arready, 1'b1);
    chk("rst_wready0", s_wready, 1'b0);
    chk("rst_bvalid0", s_bvalid, 1'b0);
    chk("rst_rvalid0", s_rvalid, 1'b0);
    chk("rst_rlast0", s_rlast, 1'b0);
    chk("rst_bid0", s_bid, 4'd0);
    chk("rst_rid0", s_rid, 4'd0);
    chk("rst_bresp0", s_bresp, 2'd0);
    chk("rst_rresp0", s_rresp, 2'd0);
    chk("rst_rdata0", s_rdata, 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // give every beat a known value
    for (int h = 0; h < 2; h++) begin
      fill_rand(255, 0);
      do_write(64'(h * 4096), 255, 4'h1, 255, -1);
    end

    wd[0] = 128'h0123456789ABCDEF0123456789ABCDEF; ws[0] = 16'hFFFF;
    do_write(64'h40, 0, 4'h5, 0, -1);
    do_read(64'h40, 0, 4'h9);

    fill_rand(15, 0);
    do_write(64'h1FF0, 15, 4'h3, 15, -1);
    rready_mode = 1;
    do_read(64'h1FF0, 15, 4'hA);
    rready_mode = 0;

    wd[0] = '1; ws[0] = 16'hFFFF;
    do_write(64'h80, 0, 4'h2, 0, -1);
    wd[0] = '0; ws[0] = 16'h00F0;
    do_write(64'h80, 0, 4'h2, 0, -1);
    do_read(64'h80, 0, 4'hB);

    fill_rand(3, 0);
    do_write(64'h1_0000_0000, 3, 4'h4, 3, -1);
    do_read(64'h0, 3, 4'hC);
    rready_mode = 2;
    do_read(64'h1_0000_0000, 3, 4'hD);
    rready_mode = 0;

    fill_rand(3, 0);
    fork
      do_write(64'h200, 3, 4'h6, 2, -1);
      do_read(64'h800, 3, 4'h7);
    join
    do_read(64'h200, 3, 4'h8);

    for (int t = 0; t < 24; t++) begin
      addr = {51'd0, 9'($urandom_range(0, 511)), 4'($urandom())};
      if ($urandom_range(0, 7) == 0) addr[63:13] = 51'($urandom_range(1, 1000));
      len = $urandom_range(0, 15);
      fill_rand(len, 1);
      do_write(addr, len, 4'($urandom()), len, -1);
      rready_mode = $urandom_range(0, 2);
      do_read(addr, len, 4'($urandom()));
      rready_mode = 0;
    end

    fill_rand(7, 0);
    do_write(64'h600, 7, 4'h3, 7, 5);
    do_read(64'h600, 7, 4'h4);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
